// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter and sequencer for a single-port synchronous RAM,
// with a clear sweep that writes CLEAR_VAL to every word.
module ram_arbiter #(
    parameter int                ADDR_W    = 3,
    parameter int                DATA_W    = 4,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    output logic              o_busy,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_ram_write_en,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_write_data,
    input  logic [DATA_W-1:0] i_ram_read_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2,
        S_CLEAR  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            r_state;
    logic              r_ptr;        // 0: master 0 wins a tie, 1: master 1 wins a tie
    logic              r_win;        // master owning the transaction in flight
    logic              r_txn_we;
    logic              r_clear_pend;
    logic              r_busy;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;

    logic              w_grant1;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    always_comb begin
        w_grant1    = i_req1 & (~i_req0 | r_ptr);
        w_sel_we    = w_grant1 ? i_we1    : i_we0;
        w_sel_addr  = w_grant1 ? i_addr1  : i_addr0;
        w_sel_wdata = w_grant1 ? i_wdata1 : i_wdata0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_ptr        <= 1'b0;
            r_win        <= 1'b0;
            r_txn_we     <= 1'b0;
            r_clear_pend <= 1'b0;
            r_busy       <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_clear || r_clear_pend) begin
                        r_state     <= S_CLEAR;
                        r_busy      <= 1'b1;
                        r_ram_addr  <= '0;
                        r_ram_wdata <= CLEAR_VAL;
                        r_ram_we    <= 1'b1;
                    end else if (i_req0 || i_req1) begin
                        r_state     <= S_ACCESS;
                        r_win       <= w_grant1;
                        r_txn_we    <= w_sel_we;
                        r_ram_we    <= w_sel_we;
                        r_ram_addr  <= w_sel_addr;
                        r_ram_wdata <= w_sel_wdata;
                    end
                end
                S_ACCESS: begin
                    r_ram_we <= 1'b0;
                    if (i_clear) r_clear_pend <= 1'b1;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (i_clear) r_clear_pend <= 1'b1;
                    if (r_win) begin
                        r_ack1 <= 1'b1;
                        if (!r_txn_we) r_rdata1 <= i_ram_read_data;
                    end else begin
                        r_ack0 <= 1'b1;
                        if (!r_txn_we) r_rdata0 <= i_ram_read_data;
                    end
                    r_ptr   <= ~r_win;
                    r_state <= S_IDLE;
                end
                S_CLEAR: begin
                    // A clear requested mid-sweep is absorbed by the sweep already running.
                    if (i_clear) r_clear_pend <= 1'b1;
                    if (r_ram_addr == LAST_ADDR) begin
                        r_ram_we     <= 1'b0;
                        r_busy       <= 1'b0;
                        r_clear_pend <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_ram_addr <= r_ram_addr + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy           = r_busy;
    assign o_ack0           = r_ack0;
    assign o_ack1           = r_ack1;
    assign o_rdata0         = r_rdata0;
    assign o_rdata1         = r_rdata1;
    assign o_ram_write_en   = r_ram_we;
    assign o_ram_addr       = r_ram_addr;
    assign o_ram_write_data = r_ram_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: behavioural 8x4 RAM, per-scenario tasks with
// hand-computed expectations.
module tb_ram_arbiter;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       busy;
    logic       req0, req1, we0, we1;
    logic [2:0] addr0, addr1;
    logic [3:0] wdata0, wdata1;
    logic       ack0, ack1;
    logic [3:0] rdata0, rdata1;
    logic       ram_we;
    logic [2:0] ram_addr;
    logic [3:0] ram_wdata;
    logic [3:0] ram_rdata;

    logic [3:0] mem [8];

    int n_vec  = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int busy_cnt = 0;
    logic [2:0] log_addr[$];
    logic [3:0] log_data[$];

    ram_arbiter #(.ADDR_W(3), .DATA_W(4), .CLEAR_VAL(4'h0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .o_busy(busy),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_ack0(ack0), .o_ack1(ack1), .o_rdata0(rdata0), .o_rdata1(rdata1),
        .o_ram_write_en(ram_we), .o_ram_addr(ram_addr),
        .o_ram_write_data(ram_wdata), .i_ram_read_data(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read data appears one edge after the address.
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 4'h0;
        ram_rdata = 4'h0;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt++;
            log_addr.push_back(ram_addr);
            log_data.push_back(ram_wdata);
        end
        if (busy) busy_cnt++;
    end

    task automatic wait_any(input int max, output int n, output logic a0, output logic a1);
        logic done;
        n = 0; a0 = 1'b0; a1 = 1'b0; done = 1'b0;
        while (!done && n < max) begin
            @(posedge clk); #1;
            n++;
            if (ack0 || ack1) begin
                a0 = ack0; a1 = ack1; done = 1'b1;
            end
        end
    endtask

    task automatic drive0(input logic r, input logic w, input logic [2:0] a, input logic [3:0] d);
        req0 = r; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic drive1(input logic r, input logic w, input logic [2:0] a, input logic [3:0] d);
        req1 = r; we1 = w; addr1 = a; wdata1 = d;
    endtask

    task automatic test_reset;
        int n; logic a0, a1;
        rst_n = 1'b0; clear = 1'b0;
        drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, ack0, ack1, ram_we, ram_addr, ram_wdata, rdata0, rdata1} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h want 0",
                     {busy, ack0, ack1, ram_we, ram_addr, ram_wdata, rdata0, rdata1});
        end
        rst_n = 1'b1;
        // Write in flight, then reset after E0.
        drive0(1, 1, 3'd6, 4'd5);
        @(posedge clk); #1;
        n_vec++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 3'd6, 4'd5}) begin
            n_fail++;
            $display("FAIL e0_register: got %0h want %0h", {ram_we, ram_addr, ram_wdata}, {1'b1, 3'd6, 4'd5});
        end
        rst_n = 1'b0;
        drive0(0, 0, 0, 0);
        #1;
        n_vec++;
        if ({busy, ack0, ack1, ram_we, ram_addr, ram_wdata, rdata0, rdata1} !== 19'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %0h want 0",
                     {busy, ack0, ack1, ram_we, ram_addr, ram_wdata, rdata0, rdata1});
        end
        #2 rst_n = 1'b1;
        wait_any(6, n, a0, a1);
        n_vec++;
        if ((a0 | a1) !== 1'b0) begin
            n_fail++;
            $display("FAIL dropped_txn_ack: got ack0=%0b ack1=%0b want none", a0, a1);
        end
        n_vec++;
        if (mem[6] !== 4'h0) begin
            n_fail++;
            $display("FAIL dropped_txn_write: got mem6=%0h want 0", mem[6]);
        end
        drive0(1, 0, 3'd0, 4'd0);
        wait_any(8, n, a0, a1);
        drive0(0, 0, 0, 0);
        n_vec++;
        if ({a0, a1, n[3:0], rdata0} !== {1'b1, 1'b0, 4'd3, 4'd0}) begin
            n_fail++;
            $display("FAIL read_after_reset: got a0=%0b a1=%0b lat=%0d rdata0=%0h want 1 0 3 0", a0, a1, n, rdata0);
        end
    endtask

    task automatic test_write_read;
        int n; logic a0, a1;
        we_cnt = 0;
        drive0(1, 1, 3'd3, 4'd7);
        wait_any(8, n, a0, a1);
        drive0(0, 0, 0, 0);
        n_vec++;
        if ({a0, n[3:0], we_cnt[3:0]} !== {1'b1, 4'd3, 4'd1}) begin
            n_fail++;
            $display("FAIL write_m0: got ack0=%0b lat=%0d we_cycles=%0d want 1 3 1", a0, n, we_cnt);
        end
        we_cnt = 0;
        drive0(1, 0, 3'd3, 4'd0);
        wait_any(8, n, a0, a1);
        drive0(0, 0, 0, 0);
        n_vec++;
        if ({a0, n[3:0], we_cnt[3:0], rdata0} !== {1'b1, 4'd3, 4'd0, 4'd7}) begin
            n_fail++;
            $display("FAIL read_m0: got ack0=%0b lat=%0d we_cycles=%0d rdata0=%0h want 1 3 0 7", a0, n, we_cnt, rdata0);
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({ack0, rdata0, rdata1} !== {1'b0, 4'd7, 4'd0}) begin
            n_fail++;
            $display("FAIL rdata_hold: got ack0=%0b rdata0=%0h rdata1=%0h want 0 7 0", ack0, rdata0, rdata1);
        end
    endtask

    task automatic test_contention;
        int n; logic a0, a1;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        drive0(1, 1, 3'd5, 4'd3);
        drive1(1, 0, 3'd5, 4'd0);
        wait_any(8, n, a0, a1);
        drive0(0, 0, 0, 0);
        n_vec++;
        if ({a0, a1, n[3:0]} !== {1'b1, 1'b0, 4'd3}) begin
            n_fail++;
            $display("FAIL tie_first_m0: got a0=%0b a1=%0b lat=%0d want 1 0 3", a0, a1, n);
        end
        wait_any(8, n, a0, a1);
        drive1(0, 0, 0, 0);
        n_vec++;
        if ({a0, a1, n[3:0], rdata1} !== {1'b0, 1'b1, 4'd3, 4'd3}) begin
            n_fail++;
            $display("FAIL tie_then_m1: got a0=%0b a1=%0b lat=%0d rdata1=%0h want 0 1 3 3", a0, a1, n, rdata1);
        end
        drive0(1, 0, 3'd5, 4'd0);
        drive1(1, 0, 3'd5, 4'd0);
        wait_any(8, n, a0, a1);
        drive0(0, 0, 0, 0);
        n_vec++;
        if ({a0, a1, rdata0} !== {1'b1, 1'b0, 4'd3}) begin
            n_fail++;
            $display("FAIL ptr_back_to_m0: got a0=%0b a1=%0b rdata0=%0h want 1 0 3", a0, a1, rdata0);
        end
        wait_any(8, n, a0, a1);
        drive1(0, 0, 0, 0);
        n_vec++;
        if ({a0, a1} !== 2'b01) begin
            n_fail++;
            $display("FAIL ptr_pending_m1: got a0=%0b a1=%0b want 0 1", a0, a1);
        end
    endtask

    task automatic test_back_to_back;
        int n; logic a0, a1;
        logic [5:0] order;
        logic [5:0] exp_order;
        exp_order = 6'b101010;   // bit k = 1 means master 1 acked k-th
        order = '0;
        drive0(1, 0, 3'd3, 4'd0);
        drive1(1, 0, 3'd5, 4'd0);
        for (int k = 0; k < 6; k++) begin
            wait_any(8, n, a0, a1);
            order[k] = a1;
            n_vec++;
            if ({n[3:0], a0 ^ a1} !== {4'd3, 1'b1}) begin
                n_fail++;
                $display("FAIL rr_spacing_%0d: got lat=%0d a0=%0b a1=%0b want 3, one ack", k, n, a0, a1);
            end
            n_vec++;
            if ((a0 ? rdata0 : rdata1) !== (a0 ? 4'd7 : 4'd3)) begin
                n_fail++;
                $display("FAIL rr_rdata_%0d: got %0h want %0h", k, a0 ? rdata0 : rdata1, a0 ? 4'd7 : 4'd3);
            end
        end
        drive0(0, 0, 0, 0);
        drive1(0, 0, 0, 0);
        n_vec++;
        if (order !== exp_order) begin
            n_fail++;
            $display("FAIL rr_order: got %b want %b", order, exp_order);
        end
    endtask

    task automatic test_clear_after_read;
        int n; logic a0, a1;
        logic ok;
        for (int i = 0; i < 8; i++) begin
            drive0(1, 1, 3'(i), 4'(i + 1));
            wait_any(8, n, a0, a1);
            drive0(0, 0, 0, 0);
            n_vec++;
            if ({a0, n[3:0]} !== {1'b1, 4'd3}) begin
                n_fail++;
                $display("FAIL fill_%0d: got ack0=%0b lat=%0d want 1 3", i, a0, n);
            end
        end
        busy_cnt = 0;
        log_addr.delete();
        log_data.delete();
        drive1(1, 0, 3'd6, 4'd0);
        @(posedge clk); #1;          // E0 taken, transaction in ACCESS
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        wait_any(4, n, a0, a1);
        drive1(0, 0, 0, 0);
        n_vec++;
        if ({a1, n[3:0], rdata1, busy} !== {1'b1, 4'd1, 4'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL read_before_clear: got ack1=%0b edges=%0d rdata1=%0h busy=%0b want 1 1 7 0", a1, n, rdata1, busy);
        end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while ((busy || n == 1) && n < 20);
        n_vec++;
        if ({busy_cnt[4:0], busy} !== {5'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_busy_cycles: got busy_cycles=%0d busy=%0b want 8 0", busy_cnt, busy);
        end
        ok = (log_addr.size() == 8);
        for (int i = 0; i < log_addr.size(); i++)
            if (log_addr[i] !== 3'(i) || log_data[i] !== 4'h0) ok = 1'b0;
        n_vec++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_sweep_writes: got %0d writes, sequence ok=%0b want 8 writes addr 0..7 data 0", log_addr.size(), ok);
        end
        drive0(1, 0, 3'd7, 4'd0);
        wait_any(8, n, a0, a1);
        drive0(0, 0, 0, 0);
        n_vec++;
        if ({a0, n[3:0], rdata0} !== {1'b1, 4'd3, 4'd0}) begin
            n_fail++;
            $display("FAIL read_after_clear: got ack0=%0b lat=%0d rdata0=%0h want 1 3 0", a0, n, rdata0);
        end
    endtask

    task automatic test_req_during_clear;
        int n; logic a0, a1;
        drive0(1, 1, 3'd2, 4'd9);
        wait_any(8, n, a0, a1);
        drive0(0, 0, 0, 0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_start: got busy=%0b want 1", busy);
        end
        drive0(1, 0, 3'd2, 4'd0);
        wait_any(15, n, a0, a1);
        drive0(0, 0, 0, 0);
        n_vec++;
        if ({a0, n[4:0], busy, rdata0} !== {1'b1, 5'd11, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL req_held_in_clear: got ack0=%0b edges=%0d busy=%0b rdata0=%0h want 1 11 0 0", a0, n, busy, rdata0);
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_contention;
        test_back_to_back;
        test_clear_after_read;
        test_req_during_clear;
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port 8x4 ram block.
- Serializes read/write transactions from two masters onto one RAM port using a req/ack handshake.
- Returns read data to the winning master.
- Provides a clear sweep that writes CLEAR_VAL to every RAM word.
- Sits between the two master blocks and the ram instance at the top level.

Parameters:
ADDR_W, 3, RAM address width; depth = 2**ADDR_W
DATA_W, 4, RAM data width
CLEAR_VAL, 0, value written to every word during a clear sweep

Ports:
i_clk  in  1  system clock, rising edge
i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
i_clear  in  1  request clear sweep (level, sampled in IDLE)
o_busy  out  1  high while a clear sweep is in progress
i_req0 / i_req1  in  1  transaction request, master 0 / 1
i_we0 / i_we1  in  1  1 = write, 0 = read
i_addr0 / i_addr1  in  ADDR_W  word address
i_wdata0 / i_wdata1  in  DATA_W  write data
o_ack0 / o_ack1  out  1  one-cycle completion pulse
o_rdata0 / o_rdata1  out  DATA_W  read data, valid while ack is high and held until next read for that master
o_ram_write_en  out  1  to ram write enable
o_ram_addr  out  ADDR_W  to ram address
o_ram_write_data  out  DATA_W  to ram write data
i_ram_read_data  in  DATA_W  from ram; valid one edge after the address is presented

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs 0; priority pointer = master 0; pending clear flag = 0. Any in-flight transaction is dropped with no ack.
- All outputs are registered.
- States: IDLE, ACCESS, RESP, CLEAR.
- IDLE, clear pending or i_clear=1 at edge:
  - go to CLEAR; o_busy=1; o_ram_addr=0; o_ram_write_data=CLEAR_VAL; o_ram_write_en=1.
  - Clear beats any request.
- IDLE, otherwise, any req high at edge E0:
  - Pick a winner: if only one req is high, grant it; if both are high, grant the master named by the priority pointer.
  - Register the winner's addr and wdata onto the RAM outputs; o_ram_write_en = winner's we.
  - Go to ACCESS.
- ACCESS (edge E1): the RAM performs the op; o_ram_write_en forced 0; go to RESP.
- RESP (edge E2):
  - On a read, capture i_ram_read_data into the winner's o_rdata.
  - Pulse the winner's ack for one cycle.
  - Set the pointer to the other master; go to IDLE.
- Latency: req sampled at E0 gives ack high during the cycle after E2. One transaction per 3 cycles.
- Handshake:
  - Master holds req, we, addr and wdata stable until its ack.
  - In the ack-high cycle the master either drops req or presents its next transaction.
  - req sampled at the next edge is treated as new.
  - The losing master's request stays pending (not acked); it is served next by round-robin.
- CLEAR:
  - One word per cycle; address increments 0..2**ADDR_W-1.
  - After the edge writing the last address: o_ram_write_en=0, o_busy=0, pending clear flag cleared, go to IDLE.
  - Total: 2**ADDR_W cycles with write_en high.
- i_clear asserted in ACCESS/RESP/CLEAR: sets the pending flag.
  - From ACCESS/RESP: the sweep starts after the current transaction returns to IDLE.
  - From CLEAR: the flag is discarded at sweep end; no second sweep.
- Requests during CLEAR are not granted and remain pending.
- Pointer is not changed by a clear sweep.
- Address arithmetic wraps modulo 2**ADDR_W. Write data is passed through unmodified.
- o_rdataX is untouched by writes and by the other master's reads.

Test Plan:
1. Reset asserted mid-transaction (after E0): all outputs 0 immediately; no ack follows; next req0 read of addr 0 completes normally.
2. Master 0 writes 7 to addr 3, then reads addr 3: o_ram_write_en high exactly one cycle; read ack after 3 cycles; o_rdata0=7.
3. Both req high at once after reset, m0 write addr 5 = 3 and m1 read addr 5: m0 acked first; m1 acked 3 cycles later with o_rdata1=3; pointer then points to m0.
4. Both masters hold continuous requests for 6 transactions: acks alternate 0,1,0,1,0,1; neither is starved.
5. Fill all 8 addresses with nonzero data, pulse i_clear while m1 has a read in flight: m1 read completes first; o_busy high 8 cycles; writes to addr 0..7 with data 0; subsequent reads of addr 7 return 0.
6. req0 held during CLEAR: no ack until o_busy falls; served immediately afterward.
